jtl_pulse_scheduler: RTL and testbench



---
 rtl/jtl_pulse_scheduler_pkg.sv | 25 ++
 rtl/jtl_pulse_scheduler_if.sv | 28 ++
 rtl/jtl_pulse_scheduler_rr_arbiter.sv | 30 +++
 rtl/jtl_pulse_scheduler.sv | 175 +++++++++++++++++
 tb/tb_jtl_pulse_scheduler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/jtl_pulse_scheduler_pkg.sv
// Shared types, default configuration and helpers for the JTL pulse scheduler.
package jtl_ctrl_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int CNT_W_DEF   = 3;
  localparam int MIN_GAP_DEF = 2;
  localparam int MAX_OUT_DEF = 4;
  localparam int TIMEOUT_DEF = 8;

  // Widths derived from the default configuration.
  localparam int PTR_W_DEF = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;
  localparam int OUT_W_DEF = $clog2(MAX_OUT_DEF + 1);
  localparam int AGE_W_DEF = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HALT = 1'b1
  } state_t;

  // Increment that sticks at max instead of wrapping.
  function automatic int sat_inc(input int value, input int max);
    return (value >= max) ? max : value + 1;
  endfunction

endpackage

// File: rtl/jtl_pulse_scheduler_if.sv
// Requester / JTL line bundle between the scheduler and its environment.
interface jtl_pulse_scheduler_if
  import jtl_ctrl_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int OUT_W = OUT_W_DEF
);
  logic [N_REQ-1:0] req;
  logic             jtl_out;
  logic             jtl_in;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] drop;
  logic [N_REQ-1:0] pend_full;
  logic [OUT_W-1:0] outstanding;
  logic             busy;
  logic             err_timeout;
  logic             err_spurious;

  modport master (
    output req, jtl_out,
    input  jtl_in, grant, drop, pend_full, outstanding, busy, err_timeout, err_spurious
  );

  modport slave (
    input  req, jtl_out,
    output jtl_in, grant, drop, pend_full, outstanding, busy, err_timeout, err_spurious
  );
endinterface

// File: rtl/jtl_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_arbiter
  import jtl_ctrl_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic [N_REQ-1:0] request,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the last slot checked is ptr itself.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!valid && request[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtl_pulse_scheduler.sv
// Shares one toggle-encoded JTL line between N_REQ requesters: buffered
// requests, round-robin grants with a minimum gap, in-flight tracking and
// timeout / spurious-return error detection.
module jtl_pulse_scheduler
  import jtl_ctrl_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rst,
  jtl_pulse_scheduler_if.slave bus
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);
  localparam int AGE_W   = $clog2(TIMEOUT + 1);
  localparam int GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next, win_idx;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [AGE_W-1:0] age_reg, age_next;
  logic [OUT_W-1:0] out_reg, out_next;
  logic [N_REQ-1:0] grant_reg, grant_next, nonzero, nonzero_next, win_oh, win_grant;
  logic             jtl_in_reg, jtl_in_next, jtl_out_q;
  logic             err_t_reg, err_t_next, err_s_reg, err_s_next;
  logic             busy_reg, busy_next;
  logic             win_valid, issue, ret;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .request (nonzero),
    .ptr     (ptr_reg),
    .winner  (win_oh),
    .valid   (win_valid)
  );

  // Arbitration only looks at registered counts, so a same-cycle request is not eligible.
  assign issue     = (state_reg == IDLE) && (gap_reg == '0) &&
                     (out_reg < OUT_W'(MAX_OUT)) && win_valid;
  assign win_grant = issue ? win_oh : '0;
  assign ret       = bus.jtl_out ^ jtl_out_q;

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_pend
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             drop_reg, drop_next, full_reg;

    // Request adds, grant removes; a request against a full counter is dropped.
    always_comb begin
      cnt_next  = cnt_reg;
      drop_next = 1'b0;
      if (bus.req[gi] && !win_grant[gi]) begin
        if (cnt_reg == CNT_W'(CNT_MAX)) drop_next = 1'b1;
        else cnt_next = CNT_W'(sat_inc(int'(cnt_reg), CNT_MAX));
      end else if (!bus.req[gi] && win_grant[gi]) begin
        cnt_next = cnt_reg - 1'b1;
      end
    end

    // Counter plus drop/full flags, full aligned with the counter value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg  <= '0;
        drop_reg <= 1'b0;
        full_reg <= 1'b0;
      end else begin
        cnt_reg  <= cnt_next;
        drop_reg <= drop_next;
        full_reg <= (cnt_next == CNT_W'(CNT_MAX));
      end
    end

    assign nonzero[gi]       = (cnt_reg != '0);
    assign nonzero_next[gi]  = (cnt_next != '0);
    assign bus.drop[gi]      = drop_reg;
    assign bus.pend_full[gi] = full_reg;
  end

  // One-hot winner to pointer index.
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_oh[k]) win_idx = PTR_W'(k);
    end
  end

  // Issue, in-flight accounting, oldest-pulse aging and the IDLE/HALT transitions.
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    gap_next    = (gap_reg != '0) ? gap_reg - 1'b1 : gap_reg;
    age_next    = age_reg;
    out_next    = out_reg;
    grant_next  = '0;
    jtl_in_next = jtl_in_reg;
    err_t_next  = err_t_reg;
    err_s_next  = err_s_reg;

    if (issue) begin
      grant_next  = win_oh;
      jtl_in_next = ~jtl_in_reg;
      ptr_next    = win_idx;
      gap_next    = GAP_W'(MIN_GAP - 1);
    end

    if (issue && !ret) begin
      out_next = out_reg + 1'b1;
    end else if (ret && !issue) begin
      if (out_reg == '0) err_s_next = 1'b1;
      else out_next = out_reg - 1'b1;
    end

    if (ret || (issue && out_reg == '0)) age_next = '0;
    else if (out_reg != '0) age_next = AGE_W'(sat_inc(int'(age_reg), TIMEOUT));

    case (state_reg)
      IDLE: begin
        if (age_next == AGE_W'(TIMEOUT)) begin
          state_next = HALT;
          err_t_next = 1'b1;
          out_next   = '0;
        end
      end
      HALT: begin
        out_next = '0;
        age_next = age_reg;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (|nonzero_next) || (out_next != '0);
  end

  // Control register file; reset parks the pointer so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= PTR_W'(N_REQ - 1);
      gap_reg    <= '0;
      age_reg    <= '0;
      out_reg    <= '0;
      grant_reg  <= '0;
      jtl_in_reg <= 1'b0;
      jtl_out_q  <= 1'b0;
      err_t_reg  <= 1'b0;
      err_s_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      gap_reg    <= gap_next;
      age_reg    <= age_next;
      out_reg    <= out_next;
      grant_reg  <= grant_next;
      jtl_in_reg <= jtl_in_next;
      jtl_out_q  <= bus.jtl_out;
      err_t_reg  <= err_t_next;
      err_s_reg  <= err_s_next;
      busy_reg   <= busy_next;
    end
  end

  assign bus.jtl_in       = jtl_in_reg;
  assign bus.grant        = grant_reg;
  assign bus.outstanding  = out_reg;
  assign bus.busy         = busy_reg;
  assign bus.err_timeout  = err_t_reg;
  assign bus.err_spurious = err_s_reg;

endmodule

// File: tb/tb_jtl_pulse_scheduler.sv
// Directed bench for jtl_pulse_scheduler with a 3-cycle JTL delay model.
module tb_jtl_pulse_scheduler;
  import jtl_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic loop_en = 1'b0;
  logic manual = 1'b0;
  logic [2:0] dly = 3'b000;
  int n_cmp = 0;
  int n_bad = 0;

  jtl_pulse_scheduler_if #(.N_REQ(4), .OUT_W(3)) bus ();

  jtl_pulse_scheduler #(
    .N_REQ(4), .CNT_W(3), .MIN_GAP(2), .MAX_OUT(4), .TIMEOUT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // JTL model: output follows jtl_in three clock edges later.
  always @(posedge clk) dly <= {dly[1:0], bus.jtl_in};
  assign bus.jtl_out = loop_en ? dly[2] : manual;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    loop_en = 1'b1;
    tick(5);
    rst = 1'b0;
  endtask

  // Saturation/timeout table: one entry per clock edge with req[2] held for 12 edges.
  logic [3:0] sat_grant [13] = '{4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [2:0] sat_out   [13] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
  logic       sat_jin   [13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       sat_tmo   [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] sat_full  [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4};
  logic [3:0] sat_drop  [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};

  logic [3:0] rr_grant [7] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
  logic       rr_jin   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    bus.req = '0;

    // Power-on reset, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst jtl_in", bus.jtl_in, 0);
    chk("rst grant", bus.grant, 0);
    chk("rst outstanding", bus.outstanding, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst err_timeout", bus.err_timeout, 0);
    chk("rst err_spurious", bus.err_spurious, 0);
    chk("rst pend_full", bus.pend_full, 0);
    chk("rst drop", bus.drop, 0);
    loop_en = 1'b1;
    tick(4);
    rst = 1'b0;

    // Single request on requester 0, returning through the delay model.
    bus.req = 4'b0001;
    tick(1);
    bus.req = 4'b0000;
    chk("single busy", bus.busy, 1);
    chk("single no early grant", bus.grant, 0);
    tick(1);
    chk("single grant", bus.grant, 4'b0001);
    chk("single jtl_in", bus.jtl_in, 1);
    chk("single outstanding", bus.outstanding, 1);
    tick(1);
    chk("single grant pulse", bus.grant, 0);
    tick(2);
    chk("single in flight", bus.outstanding, 1);
    tick(1);
    chk("single returned", bus.outstanding, 0);
    chk("single busy idle", bus.busy, 0);
    chk("single err_spurious", bus.err_spurious, 0);
    chk("single err_timeout", bus.err_timeout, 0);

    // Round-robin from a fresh pointer with the two-cycle gap.
    do_reset();
    bus.req = 4'b1111;
    tick(1);
    bus.req = 4'b0000;
    for (int s = 0; s < 7; s++) begin
      tick(1);
      chk($sformatf("rr%0d grant", s), bus.grant, rr_grant[s]);
      chk($sformatf("rr%0d jtl_in", s), bus.jtl_in, rr_jin[s]);
    end
    chk("rr outstanding", bus.outstanding, 2);
    tick(4);
    chk("rr drained", bus.outstanding, 0);
    chk("rr busy", bus.busy, 0);
    chk("rr err_spurious", bus.err_spurious, 0);

    // Saturation with a dead line: MAX_OUT cap, timeout halt, counting in HALT.
    do_reset();
    loop_en = 1'b0;
    manual = 1'b0;
    for (int s = 0; s < 13; s++) begin
      bus.req = (s < 12) ? 4'b0100 : 4'b0000;
      tick(1);
      chk($sformatf("sat%0d grant", s), bus.grant, sat_grant[s]);
      chk($sformatf("sat%0d outstanding", s), bus.outstanding, sat_out[s]);
      chk($sformatf("sat%0d jtl_in", s), bus.jtl_in, sat_jin[s]);
      chk($sformatf("sat%0d err_timeout", s), bus.err_timeout, sat_tmo[s]);
      chk($sformatf("sat%0d pend_full", s), bus.pend_full, sat_full[s]);
      chk($sformatf("sat%0d drop", s), bus.drop, sat_drop[s]);
    end
    bus.req = 4'b0000;
    tick(3);
    chk("halt busy", bus.busy, 1);
    chk("halt no grant", bus.grant, 0);
    chk("halt err_spurious", bus.err_spurious, 0);

    // Spurious return with nothing in flight.
    do_reset();
    loop_en = 1'b0;
    manual = 1'b0;
    chk("halt cleared", bus.err_timeout, 0);
    manual = 1'b1;
    tick(1);
    chk("spur err_spurious", bus.err_spurious, 1);
    chk("spur outstanding", bus.outstanding, 0);
    bus.req = 4'b0001;
    tick(1);
    bus.req = 4'b0000;
    tick(1);
    chk("spur grant", bus.grant, 4'b0001);
    chk("spur outstanding after grant", bus.outstanding, 1);
    manual = 1'b0;
    tick(1);
    chk("spur return", bus.outstanding, 0);
    chk("spur sticky", bus.err_spurious, 1);
    chk("spur err_timeout", bus.err_timeout, 0);

    // Reset while two pulses are in flight.
    do_reset();
    bus.req = 4'b0011;
    tick(1);
    bus.req = 4'b0000;
    tick(1);
    chk("mid grant0", bus.grant, 4'b0001);
    tick(2);
    chk("mid grant1", bus.grant, 4'b0010);
    chk("mid outstanding", bus.outstanding, 2);
    #2;
    rst = 1'b1;
    loop_en = 1'b0;
    manual = 1'b0;
    #1;
    chk("mid rst jtl_in", bus.jtl_in, 0);
    chk("mid rst grant", bus.grant, 0);
    chk("mid rst outstanding", bus.outstanding, 0);
    chk("mid rst busy", bus.busy, 0);
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("mid post err_spurious", bus.err_spurious, 0);
    manual = 1'b1;
    tick(1);
    chk("mid trailing edge", bus.err_spurious, 1);
    chk("mid trailing outstanding", bus.outstanding, 0);
    bus.req = 4'b0011;
    tick(1);
    bus.req = 4'b0000;
    tick(1);
    chk("mid first grant", bus.grant, 4'b0001);
    chk("mid first jtl_in", bus.jtl_in, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
